// File: rtl/comb_gate_bist4.sv
// rtl/comb_gate_bist4.sv - sequential BIST driver/checker for a 4-input 1-output gate block
// Optional MISR signature compiled in with `define COMB_BIST_MISR_EN.
module comb_gate_bist4 #(
  parameter logic [15:0] EXPECTED_TT = 16'h111F,
  parameter int unsigned SETTLE      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  pattern,
  input  logic        dut_out,
  output logic [4:0]  err_count,
  output logic [15:0] fail_map,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       mismatch;
  logic [4:0] err_next;

  // Compare the gate response with the truth table entry for the current pattern.
  always_comb begin
    mismatch = (dut_out != EXPECTED_TT[pattern]);
    err_next = err_count + {4'b0000, mismatch};
  end

`ifdef COMB_BIST_MISR_EN
  logic [15:0] misr_next;

  // CRC-16 (0x1021) style MISR step folding the sampled gate output into bit 0.
  always_comb begin
    misr_next = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000)
                ^ {15'b0, dut_out};
  end
`else
  assign signature = 16'h0000;
`endif

  // Sweep controller: one settle window per pattern, sample on its last edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      pattern    <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= 5'd0;
      fail_map   <= 16'h0000;
      pass       <= 1'b0;
`ifdef COMB_BIST_MISR_EN
      signature  <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= RUN;
            pattern    <= 4'd0;
            settle_cnt <= SETTLE_RELOAD;
            busy       <= 1'b1;
            err_count  <= 5'd0;
            fail_map   <= 16'h0000;
            pass       <= 1'b0;
`ifdef COMB_BIST_MISR_EN
            signature  <= 16'h0000;
`endif
          end
        end
        RUN: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            if (mismatch) begin
              fail_map[pattern] <= 1'b1;
            end
            err_count <= err_next;
`ifdef COMB_BIST_MISR_EN
            signature <= misr_next;
`endif
            if (pattern != 4'hF) begin
              pattern    <= pattern + 4'd1;
              settle_cnt <= SETTLE_RELOAD;
            end else begin
              // Final pattern: pass must include this last sample, so use err_next.
              state   <= DONE;
              busy    <= 1'b0;
              pattern <= 4'd0;
              done    <= 1'b1;
              pass    <= (err_next == 5'd0);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
